// File: rtl/ecpri_tx_resp.sv
// ecpri_tx_resp: builds an eCPRI Remote Memory Access response frame in the
// TX frame RAM, one byte per clock, then pulses tx_start with the frame length.
// Frame order: copied Eth/IP/UDP header (MACs swapped), eCPRI common header,
// remote-memory header, optional read payload.
// Optional feature macro: ECPRI_TX_PAD_EN -- zero-pads short frames to 60 bytes.
`timescale 1ns/1ps
module ecpri_tx_resp #(
  parameter int         DATA_WIDTH = 8,
  parameter int         ADDR_WIDTH = 16,
  parameter int         HDR_LEN    = 42,
  parameter logic [7:0] ECPRI_REV  = 8'h10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send_read_resp,
  input  logic                  send_write_resp,
  input  logic [7:0]            resp_payload_len,
  input  logic [7:0]            rm_acc_id,
  input  logic [15:0]           rm_ele_id,
  input  logic [47:0]           rm_addr,
  output logic [ADDR_WIDTH-1:0] addr_h,
  input  logic [DATA_WIDTH-1:0] data_h,
  output logic                  oe_h,
  output logic [ADDR_WIDTH-1:0] addr_p,
  input  logic [DATA_WIDTH-1:0] data_p,
  output logic                  oe_p,
  output logic [ADDR_WIDTH-1:0] addr_t,
  output logic [DATA_WIDTH-1:0] data_t,
  output logic                  we_t,
  output logic                  tx_start,
  output logic [15:0]           tx_len,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COPY_HDR,
    S_ECPRI_HDR,
    S_RM_HDR,
    S_PAYLOAD,
    S_PAD,
    S_DONE
  } state_t;

  // Where the byte written to the TX RAM comes from.
  typedef enum logic [1:0] {
    SEL_CONST,
    SEL_HDR,
    SEL_PAY
  } sel_t;

  // Byte offsets of each frame section.
  localparam logic [15:0] ECPRI_OFS = 16'(HDR_LEN);
  localparam logic [15:0] RM_OFS    = 16'(HDR_LEN + 4);
  localparam logic [15:0] PAY_OFS   = 16'(HDR_LEN + 16);
`ifdef ECPRI_TX_PAD_EN
  localparam logic [15:0] MIN_FRAME = 16'd60;
`endif

  // Section that frame byte c belongs to.
  function automatic state_t state_for(input logic [15:0] c, input logic rd,
                                       input logic [7:0] n);
    logic [15:0] lim;
    lim = PAY_OFS + (rd ? {8'h00, n} : 16'h0000);
    if (c < ECPRI_OFS)    return S_COPY_HDR;
    else if (c < RM_OFS)  return S_ECPRI_HDR;
    else if (c < PAY_OFS) return S_RM_HDR;
    else if (c < lim)     return S_PAYLOAD;
`ifdef ECPRI_TX_PAD_EN
    else if (c < MIN_FRAME) return S_PAD;
`endif
    else return S_DONE;
  endfunction

  // Source header byte for TX byte c: destination and source MACs trade places.
  function automatic logic [15:0] hdr_src(input logic [15:0] c);
    if (c < 16'd6)       return c + 16'd6;
    else if (c < 16'd12) return c - 16'd6;
    else                 return c;
  endfunction

  // eCPRI common header byte idx (0..3).
  function automatic logic [7:0] ecpri_byte(input logic [15:0] idx, input logic rd,
                                            input logic [7:0] n);
    logic [15:0] size;
    size = 16'd12 + (rd ? {8'h00, n} : 16'h0000);
    case (idx)
      16'd0:   return ECPRI_REV;
      16'd1:   return 8'h04;
      16'd2:   return size[15:8];
      default: return size[7:0];
    endcase
  endfunction

  // Remote-memory header byte idx (0..11).
  function automatic logic [7:0] rm_byte(input logic [15:0] idx, input logic rd,
                                         input logic [7:0] n, input logic [7:0] acc,
                                         input logic [15:0] ele, input logic [47:0] a);
    case (idx)
      16'd0:   return acc;
      16'd1:   return rd ? 8'h01 : 8'h11;
      16'd2:   return ele[15:8];
      16'd3:   return ele[7:0];
      16'd4:   return a[47:40];
      16'd5:   return a[39:32];
      16'd6:   return a[31:24];
      16'd7:   return a[23:16];
      16'd8:   return a[15:8];
      16'd9:   return a[7:0];
      16'd10:  return 8'h00;
      default: return n;
    endcase
  endfunction

  state_t                state_q;
  logic [15:0]           cnt_q;
  logic                  is_read_q;
  logic [7:0]            n_q;
  logic [7:0]            acc_q;
  logic [15:0]           ele_q;
  logic [47:0]           raddr_q;
  logic                  busy_q;
  logic                  tx_start_q;
  logic [15:0]           tx_len_q;
  logic [ADDR_WIDTH-1:0] addr_h_q;
  logic                  oe_h_q;
  logic [ADDR_WIDTH-1:0] addr_p_q;
  logic                  oe_p_q;
  // Byte issued last cycle; written once its RAM read data has arrived.
  logic                  pend_vld_q;
  logic [15:0]           pend_idx_q;
  sel_t                  pend_sel_q;
  logic [DATA_WIDTH-1:0] pend_const_q;
  logic                  we_t_q;
  logic [ADDR_WIDTH-1:0] addr_t_q;
  sel_t                  sel_q;
  logic [DATA_WIDTH-1:0] const_q;

  logic                  accept_d;
  state_t                cur_state_d;
  logic [15:0]           cur_cnt_d;
  logic                  cur_read_d;
  logic [7:0]            cur_n_d;
  logic                  emit_d;
  sel_t                  iss_sel_d;
  logic [DATA_WIDTH-1:0] iss_const_d;
  logic                  rd_h_d;
  logic [ADDR_WIDTH-1:0] addr_h_d;
  logic                  rd_p_d;
  logic [ADDR_WIDTH-1:0] addr_p_d;
  logic [15:0]           nxt_cnt_d;
  state_t                nxt_state_d;

  // Decode the byte to issue this cycle; an accepted request issues byte 0 at once.
  always_comb begin
    accept_d    = (state_q == S_IDLE) && !busy_q && (send_read_resp || send_write_resp);
    cur_state_d = accept_d ? S_COPY_HDR : state_q;
    cur_cnt_d   = accept_d ? 16'd0 : cnt_q;
    cur_read_d  = accept_d ? send_read_resp : is_read_q;
    cur_n_d     = accept_d ? resp_payload_len : n_q;
    emit_d      = 1'b0;
    iss_sel_d   = SEL_CONST;
    iss_const_d = '0;
    rd_h_d      = 1'b0;
    addr_h_d    = '0;
    rd_p_d      = 1'b0;
    addr_p_d    = '0;
    nxt_cnt_d   = cur_cnt_d + 16'd1;
    nxt_state_d = state_for(nxt_cnt_d, cur_read_d, cur_n_d);
    case (cur_state_d)
      S_COPY_HDR: begin
        emit_d    = 1'b1;
        iss_sel_d = SEL_HDR;
        rd_h_d    = 1'b1;
        addr_h_d  = ADDR_WIDTH'(hdr_src(cur_cnt_d));
      end
      S_ECPRI_HDR: begin
        emit_d      = 1'b1;
        iss_const_d = DATA_WIDTH'(ecpri_byte(cur_cnt_d - ECPRI_OFS, cur_read_d, cur_n_d));
      end
      S_RM_HDR: begin
        emit_d      = 1'b1;
        iss_const_d = DATA_WIDTH'(rm_byte(cur_cnt_d - RM_OFS, cur_read_d, cur_n_d,
                                          acc_q, ele_q, raddr_q));
      end
      S_PAYLOAD: begin
        emit_d    = 1'b1;
        iss_sel_d = SEL_PAY;
        rd_p_d    = 1'b1;
        addr_p_d  = ADDR_WIDTH'(cur_cnt_d - PAY_OFS);
      end
      S_PAD: begin
        emit_d      = 1'b1;
        iss_const_d = '0;
      end
      default: ;
    endcase
  end

  // Frame sequencer: request latch, read issue, delayed TX write, completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      is_read_q    <= 1'b0;
      n_q          <= '0;
      acc_q        <= '0;
      ele_q        <= '0;
      raddr_q      <= '0;
      busy_q       <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_len_q     <= '0;
      addr_h_q     <= '0;
      oe_h_q       <= 1'b0;
      addr_p_q     <= '0;
      oe_p_q       <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_idx_q   <= '0;
      pend_sel_q   <= SEL_CONST;
      pend_const_q <= '0;
      we_t_q       <= 1'b0;
      addr_t_q     <= '0;
      sel_q        <= SEL_CONST;
      const_q      <= '0;
    end else begin
      // The write lags its issue by one cycle so RAM read data lines up.
      we_t_q     <= pend_vld_q;
      addr_t_q   <= pend_vld_q ? ADDR_WIDTH'(pend_idx_q) : '0;
      sel_q      <= pend_vld_q ? pend_sel_q : SEL_CONST;
      const_q    <= pend_vld_q ? pend_const_q : '0;

      oe_h_q     <= 1'b0;
      addr_h_q   <= '0;
      oe_p_q     <= 1'b0;
      addr_p_q   <= '0;
      pend_vld_q <= 1'b0;
      tx_start_q <= 1'b0;

      if (accept_d) begin
        is_read_q <= send_read_resp;
        n_q       <= resp_payload_len;
        acc_q     <= rm_acc_id;
        ele_q     <= rm_ele_id;
        raddr_q   <= rm_addr;
        busy_q    <= 1'b1;
      end

      if (emit_d) begin
        pend_vld_q   <= 1'b1;
        pend_idx_q   <= cur_cnt_d;
        pend_sel_q   <= iss_sel_d;
        pend_const_q <= iss_const_d;
        oe_h_q       <= rd_h_d;
        addr_h_q     <= addr_h_d;
        oe_p_q       <= rd_p_d;
        addr_p_q     <= addr_p_d;
        cnt_q        <= nxt_cnt_d;
        state_q      <= nxt_state_d;
      end

      case (state_q)
        // busy still high here means this is the tx_start cycle; release it.
        S_IDLE: begin
          if (busy_q) busy_q <= 1'b0;
        end
        // Wait for the final pending write, then report the frame length.
        S_DONE: begin
          if (!pend_vld_q) begin
            tx_start_q <= 1'b1;
            tx_len_q   <= cnt_q;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // TX write data: live RAM data for copied bytes, registered constant otherwise.
  always_comb begin
    data_t = '0;
    if (we_t_q) begin
      case (sel_q)
        SEL_HDR: data_t = data_h;
        SEL_PAY: data_t = data_p;
        default: data_t = const_q;
      endcase
    end
  end

  assign addr_h   = addr_h_q;
  assign oe_h     = oe_h_q;
  assign addr_p   = addr_p_q;
  assign oe_p     = oe_p_q;
  assign addr_t   = addr_t_q;
  assign we_t     = we_t_q;
  assign tx_start = tx_start_q;
  assign tx_len   = tx_len_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ecpri_tx_resp.sv
// Testbench for ecpri_tx_resp: table of directed frames, reset/busy corner
// sequences and random frames checked against a queue-based frame builder.
`timescale 1ns/1ps
module tb_ecpri_tx_resp;

  localparam int HDR_LEN = 42;
`ifdef ECPRI_TX_PAD_EN
  localparam int MIN_LEN = 60;
`else
  localparam int MIN_LEN = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        send_read_resp, send_write_resp;
  logic [7:0]  resp_payload_len, rm_acc_id;
  logic [15:0] rm_ele_id;
  logic [47:0] rm_addr;
  logic [15:0] addr_h, addr_p, addr_t, tx_len;
  logic [7:0]  data_h, data_p, data_t;
  logic        oe_h, oe_p, we_t, tx_start, busy;

  ecpri_tx_resp dut (
    .clk(clk), .reset(reset),
    .send_read_resp(send_read_resp), .send_write_resp(send_write_resp),
    .resp_payload_len(resp_payload_len), .rm_acc_id(rm_acc_id),
    .rm_ele_id(rm_ele_id), .rm_addr(rm_addr),
    .addr_h(addr_h), .data_h(data_h), .oe_h(oe_h),
    .addr_p(addr_p), .data_p(data_p), .oe_p(oe_p),
    .addr_t(addr_t), .data_t(data_t), .we_t(we_t),
    .tx_start(tx_start), .tx_len(tx_len), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] hdr_mem [0:63];
  logic [7:0] pay_mem [0:255];
  logic [7:0] tx_mem  [0:511];
  logic [7:0] exp_frame [0:511];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Monitor state (written only by the monitor).
  int          wr_total = 0, p_total = 0, oeh_total = 0, start_total = 0, seq_err = 0;
  int          first_we_cyc = 0, start_cyc = 0;
  logic [15:0] last_waddr = 16'd0, last_p = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Header/payload RAMs with one-cycle read latency.
  always @(posedge clk) begin
    if (oe_h) data_h <= hdr_mem[addr_h[5:0]];
    if (oe_p) data_p <= pay_mem[addr_p[7:0]];
  end

  // TX RAM and activity monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (we_t) begin
      if (addr_t < 16'd512) tx_mem[addr_t[8:0]] <= data_t;
      wr_total <= wr_total + 1;
      if (addr_t != 16'd0 && addr_t != last_waddr + 16'd1) seq_err <= seq_err + 1;
      if (addr_t == 16'd0) first_we_cyc <= cyc;
      last_waddr <= addr_t;
    end
    if (oe_p) begin
      p_total <= p_total + 1;
      if (addr_p != 16'd0 && addr_p != last_p + 16'd1) seq_err <= seq_err + 1;
      last_p <= addr_p;
    end
    if (oe_h) oeh_total <= oeh_total + 1;
    if (tx_start) begin
      start_total <= start_total + 1;
      start_cyc   <= cyc;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_addr"}, {16'h0, addr_h, addr_p, addr_t}, 64'h0);
    check({name, "_ctl"}, {35'h0, oe_h, oe_p, data_t, we_t, tx_start, tx_len, busy}, 64'h0);
  endtask

  function automatic int padded(input int l);
    return (l < MIN_LEN) ? MIN_LEN : l;
  endfunction

  // Reference frame assembled straight from the frame layout rules.
  task automatic build_expected(input logic rd, input logic [7:0] n, input logic [7:0] acc,
                                input logic [15:0] ele, input logic [47:0] a, output int len);
    logic [7:0]  q[$];
    logic [7:0]  t;
    logic [15:0] psize;
    for (int i = 0; i < HDR_LEN; i++) q.push_back(hdr_mem[i]);
    for (int k = 0; k < 6; k++) begin
      t = q[k]; q[k] = q[k+6]; q[k+6] = t;
    end
    psize = 16'd12 + (rd ? {8'h00, n} : 16'd0);
    q.push_back(8'h10); q.push_back(8'h04); q.push_back(psize[15:8]); q.push_back(psize[7:0]);
    q.push_back(acc); q.push_back(rd ? 8'h01 : 8'h11);
    q.push_back(ele[15:8]); q.push_back(ele[7:0]);
    for (int b = 5; b >= 0; b--) q.push_back(a[b*8 +: 8]);
    q.push_back(8'h00); q.push_back(n);
    if (rd) for (int i = 0; i < int'(n); i++) q.push_back(pay_mem[i]);
    while (q.size() < MIN_LEN) q.push_back(8'h00);
    len = q.size();
    for (int i = 0; i < len; i++) exp_frame[i] = q[i];
  endtask

  task automatic run_frame(input string tag, input logic rd, input logic wr, input logic [7:0] n,
                           input logic [7:0] acc, input logic [15:0] ele, input logic [47:0] a,
                           input int extra_at, input int exp_len, input int exp_pcnt);
    int c0, w0, p0, s0, h0, e0, mlen, mism, first_bad;
    build_expected(rd, n, acc, ele, a, mlen);
    @(posedge clk); #1;
    w0 = wr_total; p0 = p_total; s0 = start_total; h0 = oeh_total; e0 = seq_err;
    check({tag, " idle_busy"}, busy, 0);
    send_read_resp = rd; send_write_resp = wr;
    resp_payload_len = n; rm_acc_id = acc; rm_ele_id = ele; rm_addr = a;
    c0 = cyc;
    @(posedge clk); #1;
    send_read_resp = 1'b0; send_write_resp = 1'b0;
    resp_payload_len = 8'($urandom); rm_acc_id = 8'($urandom);
    rm_ele_id = 16'($urandom); rm_addr = {16'($urandom), 32'($urandom)};
    check({tag, " busy_rise"}, busy, 1);
    for (int k = 1; k < 600 && start_total == s0; k++) begin
      @(negedge clk); #1;
      send_write_resp = (k == extra_at);
    end
    send_write_resp = 1'b0;
    if (start_total == s0) begin
      check({tag, " tx_start_timeout"}, 0, 1);
      return;
    end
    check({tag, " tx_len"}, tx_len, exp_len);
    check({tag, " busy_at_start"}, busy, 1);
    check({tag, " latency"}, start_cyc - c0, exp_len + 2);
    check({tag, " first_we"}, first_we_cyc - c0, 2);
    @(negedge clk); #1;
    check({tag, " busy_drop"}, {busy, tx_start}, 0);
    repeat ((extra_at > 0) ? 80 : 3) @(negedge clk);
    #1;
    check({tag, " start_count"}, start_total - s0, 1);
    check({tag, " write_count"}, wr_total - w0, exp_len);
    check({tag, " addr_sequence"}, seq_err - e0, 0);
    check({tag, " last_waddr"}, last_waddr, exp_len - 1);
    check({tag, " oe_p_count"}, p_total - p0, exp_pcnt);
    check({tag, " oe_h_count"}, oeh_total - h0, HDR_LEN);
    if (exp_pcnt > 0) check({tag, " last_addr_p"}, last_p, exp_pcnt - 1);
    mism = 0; first_bad = -1;
    for (int i = 0; i < mlen; i++)
      if (tx_mem[i] !== exp_frame[i]) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
    if (mism != 0) $display("[TB] %s first differing byte index %0d", tag, first_bad);
    check({tag, " frame_bytes_bad"}, mism, 0);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  n;
    logic [7:0]  acc;
    logic [15:0] ele;
    logic [47:0] a;
    int          extra_at;
    int          exp_len;
    int          exp_pcnt;
  } vec_t;

  typedef struct {
    int         v;
    int         idx;
    logic [7:0] val;
  } spot_t;

  vec_t  vecs  [6];
  spot_t spots [16];

  initial begin
    int s0, w0, len;
    logic rd;
    logic [7:0] n;

    vecs[0] = '{1'b0, 1'b1, 8'd8,   8'h5A, 16'h1234, 48'h0000_DEAD_BEEF, -1, padded(58), 0};
    vecs[1] = '{1'b1, 1'b0, 8'd4,   8'h3C, 16'hABCD, 48'h1122_3344_5566, -1, 62, 4};
    vecs[2] = '{1'b1, 1'b0, 8'd0,   8'h01, 16'h0F0F, 48'h0000_0000_0001, -1, padded(58), 0};
    vecs[3] = '{1'b1, 1'b1, 8'd3,   8'h77, 16'h8001, 48'hFFFF_0000_FFFF, 10, padded(61), 3};
    vecs[4] = '{1'b1, 1'b0, 8'd255, 8'hE1, 16'h5555, 48'hA5A5_A5A5_A5A5, -1, 313, 255};
    vecs[5] = '{1'b0, 1'b1, 8'd0,   8'h99, 16'h0000, 48'h8000_0000_0000, -1, padded(58), 0};

    spots[0]  = '{0, 0, 8'd6};    spots[1]  = '{0, 5, 8'd11};
    spots[2]  = '{0, 6, 8'd0};    spots[3]  = '{0, 11, 8'd5};
    spots[4]  = '{0, 42, 8'h10};  spots[5]  = '{0, 43, 8'h04};
    spots[6]  = '{0, 44, 8'h00};  spots[7]  = '{0, 45, 8'h0C};
    spots[8]  = '{0, 47, 8'h11};  spots[9]  = '{0, 56, 8'h00};
    spots[10] = '{0, 57, 8'h08};  spots[11] = '{1, 44, 8'h00};
    spots[12] = '{1, 45, 8'h10};  spots[13] = '{1, 47, 8'h01};
    spots[14] = '{1, 58, 8'hA0};  spots[15] = '{1, 61, 8'hA3};

    reset = 1'b1;
    send_read_resp = 1'b0; send_write_resp = 1'b0;
    resp_payload_len = '0; rm_acc_id = '0; rm_ele_id = '0; rm_addr = '0;
    for (int i = 0; i < 64; i++) hdr_mem[i] = 8'(i);
    for (int i = 0; i < 256; i++) pay_mem[i] = 8'(8'hA0 + i);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk); reset = 1'b0;

    // Directed frames.
    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].n, vecs[i].acc,
                vecs[i].ele, vecs[i].a, vecs[i].extra_at, vecs[i].exp_len, vecs[i].exp_pcnt);
      for (int s = 0; s < 16; s++)
        if (spots[s].v == i)
          check($sformatf("vec%0d tx[%0d]", i, spots[s].idx), tx_mem[spots[s].idx], spots[s].val);
    end

    // Reset in the middle of a read response.
    @(posedge clk); #1;
    s0 = start_total; w0 = wr_total;
    send_read_resp = 1'b1; resp_payload_len = 8'd16;
    @(posedge clk); #1;
    send_read_resp = 1'b0;
    for (int k = 0; k < 200 && (wr_total - w0) < 20; k++) begin
      @(negedge clk); #1;
    end
    check("midrst reached_byte20", wr_total - w0, 20);
    reset = 1'b1;
    #1;
    check_zero("midrst_async");
    @(posedge clk); #1;
    check_zero("midrst_edge");
    @(negedge clk); reset = 1'b0;
    repeat (80) @(negedge clk);
    #1;
    check("midrst no_tx_start", start_total - s0, 0);
    for (int i = 0; i < 64; i++) hdr_mem[i] = 8'($urandom);
    run_frame("post_reset", 1'b1, 1'b0, 8'd5, 8'h42, 16'hBEEF, 48'h0102_0304_0506, -1, padded(63), 5);

    // Random frames against the reference builder.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 64; i++) hdr_mem[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) pay_mem[i] = 8'($urandom);
      rd = 1'($urandom);
      n = 8'($urandom_range(0, 90));
      len = padded(HDR_LEN + 16 + (rd ? int'(n) : 0));
      run_frame($sformatf("rand%0d", r), rd, ~rd, n, 8'($urandom), 16'($urandom),
                {16'($urandom), 32'($urandom)}, -1, len, rd ? int'(n) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit, expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
